// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the mux_scan channel multiplexer.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_scan_ptr.sv
// scan_ptr: channel pointer with dwell counter; strobes adv_o on the edge that moves to the next channel.
module scan_ptr
    import mux_scan_pkg::*;
#(
    parameter int  CH    = 4,
    parameter int  DWELL = 1,
    localparam int SLW   = clog2(CH)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic [SLW-1:0] load_val_i,
    input  logic           clear_i,
    input  logic           step_i,
    output logic [SLW-1:0] ptr_o,
    output logic           adv_o
);
    // A one-cycle dwell still needs a 1-bit counter that is always at its last value.
    localparam int             DCW      = (DWELL > 1) ? clog2(DWELL) : 1;
    localparam logic [DCW-1:0] DC_LAST  = DCW'(DWELL - 1);
    localparam logic [SLW-1:0] PTR_LAST = SLW'(CH - 1);

    logic [SLW-1:0] ptr_q, ptr_d;
    logic [DCW-1:0] dc_q, dc_d;

    assign adv_o = step_i && (dc_q == DC_LAST);
    assign ptr_o = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        dc_d  = dc_q;
        if (load_i) begin
            ptr_d = load_val_i;
            dc_d  = '0;
        end else if (clear_i) begin
            dc_d = '0;
        end else if (step_i) begin
            if (dc_q == DC_LAST) begin
                dc_d  = '0;
                ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + SLW'(1);
            end else begin
                dc_d = dc_q + DCW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            dc_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            dc_q  <= dc_d;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// mux_scan: registered CH-way mux, either manually selected or scanned with a per-channel dwell.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int  CH    = 4,
    parameter int  W     = 1,
    parameter int  DWELL = 1,
    localparam int SLW   = clog2(CH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CH*W-1:0]   IN,
    input  logic [SLW-1:0]    SL,
    input  logic              MODE,
    input  logic              EN,
    output logic [W-1:0]      OUT,
    output logic [SLW-1:0]    CH_OUT,
    output logic              VLD
);
    localparam logic [SLW:0] CH_LIM = (SLW + 1)'(CH);

    logic           prev_mode_q;
    logic [W-1:0]   out_q, out_d;
    logic [SLW-1:0] ch_out_q, ch_out_d;
    logic           vld_q, vld_d;
    logic           scan_entry, scan_run;
    logic [SLW-1:0] ptr, sel_idx, entry_ptr;
    logic           adv;
    logic [W-1:0]   sel_data;

    assign scan_entry = (MODE == MODE_SCAN) && (prev_mode_q == MODE_MANUAL);
    assign scan_run   = (MODE == MODE_SCAN) && (prev_mode_q == MODE_SCAN);
    // Out-of-range start channels begin the scan at channel 0.
    assign entry_ptr  = ({1'b0, SL} < CH_LIM) ? SL : '0;

    scan_ptr #(
        .CH    (CH),
        .DWELL (DWELL)
    ) u_scan_ptr (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (scan_entry),
        .load_val_i (entry_ptr),
        .clear_i    (MODE == MODE_MANUAL),
        .step_i     (scan_run && EN),
        .ptr_o      (ptr),
        .adv_o      (adv)
    );

    assign sel_idx = scan_run ? ptr : SL;

    // Indices with no matching channel leave sel_data at zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (sel_idx == SLW'(k)) begin
                sel_data = IN[k*W +: W];
            end
        end
    end

    always_comb begin
        out_d    = sel_data;
        ch_out_d = sel_idx;
        vld_d    = 1'b0;
        if (MODE == MODE_MANUAL) begin
            vld_d = 1'b1;
        end else if (scan_run) begin
            vld_d = adv;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_mode_q <= MODE_MANUAL;
            out_q       <= '0;
            ch_out_q    <= '0;
            vld_q       <= 1'b0;
        end else begin
            prev_mode_q <= MODE;
            out_q       <= out_d;
            ch_out_q    <= ch_out_d;
            vld_q       <= vld_d;
        end
    end

    assign OUT    = out_q;
    assign CH_OUT = ch_out_q;
    assign VLD    = vld_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three instances (CH4/DW3, CH3/DW2, CH4/DW1) share stimulus, checked against an arithmetic model.
module tb_mux_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  sl = 2'd0;
    logic [31:0] in4 = 32'h0;
    logic [23:0] in3;

    logic [7:0]  oa, ob, oc;
    logic [1:0]  ca, cb, cc;
    logic        va, vb, vc;

    int n_pass = 0;
    int n_total = 0;

    // model state per instance
    int          chn [3] = '{4, 3, 4};
    int          dwl [3] = '{3, 2, 1};
    logic        m_prev [3];
    int          m_s [3];
    int          m_e [3];
    logic [7:0]  x_o [3];
    logic [1:0]  x_c [3];
    logic        x_v [3];

    assign in3 = in4[23:0];

    always #5 clk = ~clk;

    mux_scan #(.CH(4), .W(8), .DWELL(3)) u_a (
        .CLK(clk), .RST(rst), .IN(in4), .SL(sl), .MODE(mode), .EN(en),
        .OUT(oa), .CH_OUT(ca), .VLD(va));
    mux_scan #(.CH(3), .W(8), .DWELL(2)) u_b (
        .CLK(clk), .RST(rst), .IN(in3), .SL(sl), .MODE(mode), .EN(en),
        .OUT(ob), .CH_OUT(cb), .VLD(vb));
    mux_scan #(.CH(4), .W(8), .DWELL(1)) u_c (
        .CLK(clk), .RST(rst), .IN(in4), .SL(sl), .MODE(mode), .EN(en),
        .OUT(oc), .CH_OUT(cc), .VLD(vc));

    function automatic logic [7:0] chan(input int i, input int idx);
        logic [31:0] v;
        if (idx >= chn[i]) return 8'h00;
        v = in4 >> (idx * 8);
        return v[7:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = 1'b0; m_s[i] = 0; m_e[i] = 0;
            x_o[i] = 8'h00; x_c[i] = 2'd0; x_v[i] = 1'b0;
        end
    endtask

    // Expected outputs after the coming edge: scan channel is start + (enabled edges / dwell).
    task automatic model_step();
        int idx;
        for (int i = 0; i < 3; i++) begin
            if (!mode) begin
                x_c[i] = sl; x_o[i] = chan(i, int'(sl)); x_v[i] = 1'b1;
            end else if (!m_prev[i]) begin
                m_s[i] = (int'(sl) < chn[i]) ? int'(sl) : 0;
                m_e[i] = 0;
                x_c[i] = sl; x_o[i] = chan(i, int'(sl)); x_v[i] = 1'b0;
            end else begin
                idx = (m_s[i] + m_e[i] / dwl[i]) % chn[i];
                x_c[i] = 2'(idx); x_o[i] = chan(i, idx);
                x_v[i] = en && ((m_e[i] % dwl[i]) == dwl[i] - 1);
                if (en) m_e[i]++;
            end
            m_prev[i] = mode;
        end
    endtask

    task automatic drive_edge(input logic m, input logic e, input logic [1:0] s);
        mode = m; en = e; sl = s;
        model_step();
        @(posedge clk); #1;
    endtask

    // Assert reset between edges, hold it across one edge, release between edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in4 = 32'h44332211;
        drive_edge(1'b0, 1'b1, 2'd3);
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_total++; if (oa !== 8'h00) $display("FAIL reset_out got %h want 00", oa); else n_pass++;
        n_total++; if (ca !== 2'd0)  $display("FAIL reset_ch got %0d want 0", ca); else n_pass++;
        n_total++; if (va !== 1'b0)  $display("FAIL reset_vld got %b want 0", va); else n_pass++;
        n_total++; if ({ob, cb, vb, oc, cc, vc} !== '0) $display("FAIL reset_others got %h want 0", {ob, cb, vb, oc, cc, vc}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({oa, ca, va} !== '0) $display("FAIL reset_held got %h want 0", {oa, ca, va}); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (va !== 1'b0) $display("FAIL first_cycle_vld got %b want 0", va); else n_pass++;
    endtask

    task automatic test_manual();
        in4 = 32'h44332211;
        drive_edge(1'b0, 1'b0, 2'd2);
        n_total++; if (oa !== 8'h33) $display("FAIL manual_out got %h want 33", oa); else n_pass++;
        n_total++; if (ca !== 2'd2)  $display("FAIL manual_ch got %0d want 2", ca); else n_pass++;
        n_total++; if (va !== 1'b1)  $display("FAIL manual_vld got %b want 1", va); else n_pass++;
        drive_edge(1'b0, 1'b1, 2'd0);
        n_total++; if (oa !== 8'h11 || ca !== 2'd0) $display("FAIL manual_ch0 got %h/%0d want 11/0", oa, ca); else n_pass++;
        in4 = 32'hA5A5A5A5;
        #2;
        n_total++; if (oa !== 8'h11) $display("FAIL manual_no_comb got %h want 11", oa); else n_pass++;
        in4 = 32'h44332211;
    endtask

    task automatic test_scan_dwell();
        int       ch_a [7] = '{3, 3, 3, 0, 0, 0, 1};
        logic     v_a  [7] = '{0, 0, 1, 0, 0, 1, 0};
        int       ch_c [7] = '{3, 0, 1, 2, 3, 0, 1};
        logic [7:0] o_a [7] = '{8'h44, 8'h44, 8'h44, 8'h11, 8'h11, 8'h11, 8'h22};
        in4 = 32'h44332211;
        drive_edge(1'b0, 1'b1, 2'd0);
        drive_edge(1'b1, 1'b1, 2'd3);
        n_total++; if (ca !== 2'd3 || va !== 1'b0 || oa !== 8'h44) $display("FAIL scan_entry got %0d/%b/%h want 3/0/44", ca, va, oa); else n_pass++;
        for (int k = 0; k < 7; k++) begin
            drive_edge(1'b1, 1'b1, 2'd1);
            n_total++; if (ca !== 2'(ch_a[k]) || va !== v_a[k]) $display("FAIL scan_seq[%0d] got %0d/%b want %0d/%b", k, ca, va, ch_a[k], v_a[k]); else n_pass++;
            n_total++; if (oa !== o_a[k]) $display("FAIL scan_out[%0d] got %h want %h", k, oa, o_a[k]); else n_pass++;
            n_total++; if (cc !== 2'(ch_c[k]) || vc !== 1'b1) $display("FAIL dwell1_seq[%0d] got %0d/%b want %0d/1", k, cc, vc, ch_c[k]); else n_pass++;
        end
    endtask

    task automatic test_en_gating();
        drive_edge(1'b0, 1'b1, 2'd0);
        drive_edge(1'b1, 1'b1, 2'd0);
        drive_edge(1'b1, 1'b1, 2'd0);
        for (int k = 0; k < 5; k++) begin
            drive_edge(1'b1, 1'b0, 2'd3);
            n_total++; if (ca !== 2'd0 || va !== 1'b0) $display("FAIL en_hold[%0d] got %0d/%b want 0/0", k, ca, va); else n_pass++;
        end
        drive_edge(1'b1, 1'b1, 2'd3);
        n_total++; if (ca !== 2'd0 || va !== 1'b0) $display("FAIL en_resume1 got %0d/%b want 0/0", ca, va); else n_pass++;
        drive_edge(1'b1, 1'b1, 2'd3);
        n_total++; if (ca !== 2'd0 || va !== 1'b1) $display("FAIL en_resume2 got %0d/%b want 0/1", ca, va); else n_pass++;
        drive_edge(1'b1, 1'b1, 2'd3);
        n_total++; if (ca !== 2'd1 || va !== 1'b0) $display("FAIL en_advance got %0d/%b want 1/0", ca, va); else n_pass++;
    endtask

    task automatic test_nonpow2();
        int         ch_b [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
        logic       v_b  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        logic [7:0] o_b  [8] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h11, 8'h11};
        in4 = 32'h44332211;
        drive_edge(1'b0, 1'b1, 2'd3);
        n_total++; if (ob !== 8'h00 || cb !== 2'd3 || vb !== 1'b1) $display("FAIL np2_manual got %h/%0d/%b want 00/3/1", ob, cb, vb); else n_pass++;
        drive_edge(1'b1, 1'b1, 2'd3);
        n_total++; if (ob !== 8'h00 || cb !== 2'd3 || vb !== 1'b0) $display("FAIL np2_entry got %h/%0d/%b want 00/3/0", ob, cb, vb); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            drive_edge(1'b1, 1'b1, 2'd3);
            n_total++; if (cb !== 2'(ch_b[k]) || vb !== v_b[k] || ob !== o_b[k]) $display("FAIL np2_seq[%0d] got %0d/%b/%h want %0d/%b/%h", k, cb, vb, ob, ch_b[k], v_b[k], o_b[k]); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        in4 = 32'h44332211;
        drive_edge(1'b0, 1'b1, 2'd0);
        drive_edge(1'b1, 1'b1, 2'd2);
        drive_edge(1'b1, 1'b1, 2'd0);
        n_total++; if (ca !== 2'd2) $display("FAIL midrst_setup got %0d want 2", ca); else n_pass++;
        mode = 1'b1; sl = 2'd1; en = 1'b1;
        do_reset();
        n_total++; if ({oa, ca, va} !== '0) $display("FAIL midrst_zero got %h want 0", {oa, ca, va}); else n_pass++;
        drive_edge(1'b1, 1'b1, 2'd1);
        n_total++; if (ca !== 2'd1 || va !== 1'b0 || oa !== 8'h22) $display("FAIL midrst_entry got %0d/%b/%h want 1/0/22", ca, va, oa); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            drive_edge(1'b1, 1'b1, 2'd3);
            n_total++; if (ca !== 2'd1 || va !== (k == 2)) $display("FAIL midrst_seq[%0d] got %0d/%b want 1/%b", k, ca, va, (k == 2)); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] ao;
        logic [1:0] ac;
        logic       av;
        logic       m;
        m = mode;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in4 = $urandom;
            if ($urandom_range(0, 15) == 0) m = ~m;
            if ($urandom_range(0, 99) == 0) do_reset();
            drive_edge(m, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
            for (int i = 0; i < 3; i++) begin
                ao = (i == 0) ? oa : (i == 1) ? ob : oc;
                ac = (i == 0) ? ca : (i == 1) ? cb : cc;
                av = (i == 0) ? va : (i == 1) ? vb : vc;
                n_total++; if (ao !== x_o[i]) $display("FAIL rand_out[%0d] cyc %0d got %h want %h", i, cyc, ao, x_o[i]); else n_pass++;
                n_total++; if (ac !== x_c[i]) $display("FAIL rand_ch[%0d] cyc %0d got %0d want %0d", i, cyc, ac, x_c[i]); else n_pass++;
                n_total++; if (av !== x_v[i]) $display("FAIL rand_vld[%0d] cyc %0d got %b want %b", i, cyc, av, x_v[i]); else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_manual();
        test_scan_dwell();
        test_en_gating();
        test_nonpow2();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 The block SHALL have parameter CH, default 4, meaning number of input channels (CH >= 2).
REQ-002 The block SHALL have parameter W, default 1, meaning bits per channel.
REQ-003 The block SHALL have parameter DWELL, default 1, meaning enabled cycles spent on each channel in scan mode (DWELL >= 1).
REQ-004 The block SHALL define derived constant SLW = ceil(log2(CH)), meaning select width.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port IN, input, CH*W bits: channel k occupies IN[k*W+W-1 : k*W].
REQ-008 The block SHALL have port SL, input, SLW bits: manual channel select; also the scan start channel.
REQ-009 The block SHALL have port MODE, input, 1 bit: 0 = manual, 1 = scan.
REQ-010 The block SHALL have port EN, input, 1 bit: scan advance enable.
REQ-011 The block SHALL have port OUT, output, W bits: registered selected channel data.
REQ-012 The block SHALL have port CH_OUT, output, SLW bits: index of the channel currently held in OUT.
REQ-013 The block SHALL have port VLD, output, 1 bit: sample-valid qualifier.

Function
REQ-014 OUT and CH_OUT SHALL be registered, with 1-cycle latency: the values captured at edge t appear after edge t.
REQ-015 In manual mode, each edge SHALL capture OUT = channel SL and CH_OUT = SL.
REQ-016 In manual mode, VLD SHALL be 1 in every cycle except the first cycle after reset release.
REQ-017 In scan mode, each edge SHALL capture OUT = channel PTR and CH_OUT = PTR, where PTR is an internal SLW-bit pointer.
REQ-018 The dwell counter DC SHALL count 0..DWELL-1 on edges where MODE=1 and EN=1; it SHALL hold when EN=0.
REQ-019 On an edge with MODE=1, EN=1 and DC=DWELL-1, DC SHALL clear and PTR SHALL advance: PTR+1, with CH-1 wrapping to 0.
REQ-020 In scan mode, VLD SHALL be 1 for exactly the one cycle after the edge described in REQ-019, marking the last dwell sample of channel CH_OUT.
REQ-021 In scan mode, VLD SHALL be 0 in all other cycles.
REQ-022 On the first edge where MODE is 1 and the registered previous mode is 0, PTR SHALL load SL, DC SHALL clear, VLD SHALL be 0, and OUT SHALL capture channel SL.
REQ-023 A scan-to-manual transition SHALL take effect on the same edge per REQ-015; DC SHALL clear and PTR SHALL hold.
REQ-024 If SL >= CH (CH not a power of two), OUT SHALL capture all zeros and CH_OUT SHALL capture SL.
REQ-025 On a scan entry with SL >= CH, PTR SHALL load 0.
REQ-026 PTR SHALL never exceed CH-1.
REQ-027 When DWELL=1, PTR SHALL advance on every enabled edge and VLD SHALL be 1 in every cycle after an enabled edge.
REQ-028 Changes on IN SHALL be reflected only through the register, never combinationally on OUT.

Reset
REQ-029 While RST=1, the block SHALL hold OUT=0, CH_OUT=0, VLD=0, PTR=0, DC=0 and the registered previous mode = 0 (manual), independent of CLK.
REQ-030 Reset asserted mid-dwell SHALL abandon the scan; after release, a MODE=1 input SHALL be treated as a fresh scan entry (REQ-022).

Structure
REQ-031 A shared package mux_scan_pkg SHALL hold a clog2 function and the constants MODE_MANUAL=0 and MODE_SCAN=1.
REQ-032 PTR, DC and the wrap/advance logic SHALL be one sub-module, scan_ptr (parameters CH, DWELL; outputs PTR and the advance strobe).
REQ-033 Channel selection plus the output registers SHALL stay in the top level; the expected size is 120-400 lines of RTL.

Verification
REQ-034 Reset: CH=4, W=8; assert RST asynchronously between edges -> OUT=0, CH_OUT=0 and VLD=0 immediately.
REQ-035 Manual: IN={8'h44,8'h33,8'h22,8'h11}, SL=2 -> one edge later OUT=8'h33, CH_OUT=2, VLD=1.
REQ-036 Scan: DWELL=3, EN=1, entered with SL=3 -> CH_OUT sequence is 3,3,3,0,0,0,1...; VLD pulses with the third 3 and with the third 0.
REQ-037 EN gating: in scan with DWELL=3, drop EN for 5 cycles at DC=1 -> CH_OUT holds; after EN returns, the advance comes 2 enabled cycles later.
REQ-038 Non-power-of-two: CH=3, SL=3, manual -> OUT=0, CH_OUT=3; scan entry with SL=3 -> PTR starts at 0 and wraps 2->0.
REQ-039 Mid-scan reset: assert RST at DC=1 with PTR=2, release with MODE=1 and SL=1 -> scan restarts at channel 1, with no VLD before 3 enabled cycles.
